// File: rtl/summer_pkg.sv
// Shared types and constants for the summer datapath and its arbiter.
//   N_IN / W_IN / W_SUM : operand count, operand width, sum width
//   operand_vec_t       : one full operand vector (32 products + bias)
//   sarb_state_t        : arbiter FSM states
package summer_pkg;

  localparam int unsigned N_IN  = 33;
  localparam int unsigned W_IN  = 32;
  localparam int unsigned W_SUM = 64;
  localparam int unsigned IDX_W = $clog2(N_IN);

  typedef logic [N_IN-1:0][W_IN-1:0] operand_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } sarb_state_t;

  // Sign-extend one operand word to the sum width.
  function automatic logic [W_SUM-1:0] sext_word(input logic [W_IN-1:0] w);
    return {{(W_SUM - W_IN){w[W_IN-1]}}, w};
  endfunction

endpackage

// File: rtl/summer_arbiter_if.sv
// Request/result bus of the summer arbiter.
//   req_valid/req_ready/req_data : per-lane operand vectors, one-hot grant
//   res_valid/res_ready          : result handshake
//   res_sum/res_id               : 64-bit signed sum and originating lane
// master = lane/consumer side, slave = arbiter side.
interface summer_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  import summer_pkg::*;

  logic [N_REQ-1:0]                      req_valid;
  logic [N_REQ-1:0]                      req_ready;
  logic [N_REQ-1:0][N_IN-1:0][W_IN-1:0]  req_data;
  logic                                  res_valid;
  logic                                  res_ready;
  logic [W_SUM-1:0]                      res_sum;
  logic [ID_W-1:0]                       res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_sum, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_sum, res_id
  );

endinterface

// File: rtl/summer.sv
// Combinational adder tree: signed sum of all operand words, exact at 64 bits.
//   op    : operand vector (words are signed 32-bit)
//   sum_c : combinational 64-bit signed sum
module summer
  import summer_pkg::*;
(
  input  operand_vec_t     op,
  output logic [W_SUM-1:0] sum_c
);

  // Accumulate sign-extended words; 33 * 2^31 cannot overflow 64 bits.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      sum_c = sum_c + sext_word(op[IDX_W'(i)]);
    end
  end

endmodule

// File: rtl/summer_arbiter.sv
// Round-robin scheduler sharing one summer between N_REQ neuron lanes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of summer_arbiter_if
//              req_* : per-lane operand vectors, one-hot combinational grant
//              res_* : registered sum and lane tag with valid/ready
// Accept -> CALC (operands registered) -> HOLD (sum registered, res_valid=1).
// A handoff in HOLD may overlap with the next accept, giving one result per
// two cycles under continuous demand.
module summer_arbiter
  import summer_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
)
(
  input  logic              clk,
  input  logic              rst,
  summer_arbiter_if.slave   bus
);

  sarb_state_t      state;
  sarb_state_t      state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  cand;
  logic             pick_found;
  logic             win;
  logic             accept;
  logic [ID_W-1:0]  id_q;
  operand_vec_t     op_q;
  logic [W_SUM-1:0] sum_c;

  // Round-robin pick: first valid lane at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ID_W'((32'(ptr) + off) % N_REQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) state_nxt = accept ? CALC : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: accept window and one-hot grant; held low during reset.
  always_comb begin
    win           = 1'b0;
    bus.req_ready = '0;
    case (state)
      IDLE:    win = 1'b1;
      HOLD:    win = bus.res_ready;
      default: win = 1'b0;
    endcase
    if (win && pick_found && !rst) begin
      bus.req_ready = N_REQ'(1) << pick_idx;
    end
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  // Pointer advance and operand/tag capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      op_q <= '0;
      id_q <= '0;
    end else if (accept) begin
      ptr  <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      op_q <= bus.req_data[pick_idx];
      id_q <= pick_idx;
    end
  end

  summer u_summer (
    .op    (op_q),
    .sum_c (sum_c)
  );

  // Result registers: captured only at the end of CALC, so a same-cycle
  // accept during handoff cannot disturb the values being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_id    <= '0;
    end else begin
      bus.res_valid <= (state_nxt == HOLD);
      if (state == CALC) begin
        bus.res_sum <= sum_c;
        bus.res_id  <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_summer_arbiter.sv
// Directed self-checking bench for summer_arbiter (N_REQ = 4).
module tb_summer_arbiter;
  import summer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  summer_arbiter_if #(.N_REQ(4)) bus ();

  summer_arbiter #(.N_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Load every word of a lane with w, and the bias word with bias.
  task automatic fill_lane(input int unsigned lane, input logic [31:0] w, input logic [31:0] bias);
    for (int unsigned j = 0; j < 32; j++) bus.req_data[2'(lane)][6'(j)] = w;
    bus.req_data[2'(lane)][6'd32] = bias;
  endtask

  task automatic test_reset;
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.res_sum !== 64'd0) begin failures++; $display("FAIL reset_res_sum got=%h exp=0", bus.res_sum); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", bus.res_id); end
    checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
    bus.req_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single;
    fill_lane(0, 32'd1, 32'd1);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_calc_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_calc_valid got=%b exp=0", bus.res_valid); end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL single_res_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_sum !== 64'd33) begin failures++; $display("FAIL single_sum got=%0d exp=33", bus.res_sum); end
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", bus.res_id); end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", bus.res_valid); end
    checks++; if (dut.ptr !== 2'd1) begin failures++; $display("FAIL single_ptr got=%0d exp=1", dut.ptr); end
  endtask

  task automatic test_negative;
    fill_lane(1, 32'h8000_0000, 32'h8000_0000);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL neg_grant got=%b exp=0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.res_sum !== 64'hFFFF_FFEF_8000_0000) begin failures++; $display("FAIL neg_sum got=%h exp=ffffffef80000000", bus.res_sum); end
    checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL neg_id got=%0d exp=1", bus.res_id); end
    @(posedge clk); #1;
    checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL neg_ptr got=%0d exp=2", dut.ptr); end
  endtask

  task automatic test_gap;
    fill_lane(1, 32'd0, 32'd7);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL gap_grant1 got=%b exp=0010", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL gap_ptr1 got=%0d exp=2", dut.ptr); end
    @(posedge clk); #1;
    checks++; if (bus.res_sum !== 64'd7) begin failures++; $display("FAIL gap_sum1 got=%0d exp=7", bus.res_sum); end
    checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL gap_id1 got=%0d exp=1", bus.res_id); end
    fill_lane(3, 32'd1, 32'd3);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL gap_grant2 got=%b exp=1000", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL gap_ptr2 got=%0d exp=0", dut.ptr); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL gap_calc_valid got=%b exp=0", bus.res_valid); end
    @(posedge clk); #1;
    checks++; if (bus.res_sum !== 64'd35) begin failures++; $display("FAIL gap_sum2 got=%0d exp=35", bus.res_sum); end
    checks++; if (bus.res_id !== 2'd3) begin failures++; $display("FAIL gap_id2 got=%0d exp=3", bus.res_id); end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL gap_idle_valid got=%b exp=0", bus.res_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    for (int unsigned i = 0; i < 4; i++) fill_lane(i, 32'd0, 32'(i));
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_rdy = 4'b0001 << (n % 4);
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, bus.req_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL rr_calc n=%0d ready=%b valid=%b exp=0000/0", n, bus.req_ready, bus.res_valid); end
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'(n % 4) || bus.res_id !== 2'(n % 4)) begin
        failures++; $display("FAIL rr_result n=%0d valid=%b sum=%0d id=%0d exp=1/%0d/%0d", n, bus.res_valid, bus.res_sum, bus.res_id, n % 4, n % 4);
      end
    end
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rr_idle_valid got=%b exp=0", bus.res_valid); end
  endtask

  task automatic test_back_to_back;
    fill_lane(1, 32'd2, 32'd2);
    fill_lane(2, 32'd3, 32'd3);
    bus.req_valid = 4'b0110;
    bus.res_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant1 got=%b exp=0010", bus.req_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'd66 || bus.res_id !== 2'd1) begin
        failures++; $display("FAIL bp_hold k=%0d valid=%b sum=%0d id=%0d exp=1/66/1", k, bus.res_valid, bus.res_sum, bus.res_id);
      end
      checks++; if (bus.req_ready !== 4'b0000 || dut.ptr !== 2'd2) begin
        failures++; $display("FAIL bp_stall k=%0d ready=%b ptr=%0d exp=0000/2", k, bus.req_ready, dut.ptr);
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_grant got=%b exp=0100", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'd66) begin failures++; $display("FAIL bp_release_res valid=%b sum=%0d exp=1/66", bus.res_valid, bus.res_sum); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_sum !== 64'd66 || bus.res_id !== 2'd1) begin
      failures++; $display("FAIL bp_handoff_kept valid=%b sum=%0d id=%0d exp=0/66/1", bus.res_valid, bus.res_sum, bus.res_id);
    end
    checks++; if (dut.ptr !== 2'd3) begin failures++; $display("FAIL bp_ptr got=%0d exp=3", dut.ptr); end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'd99 || bus.res_id !== 2'd2) begin
      failures++; $display("FAIL bp_second valid=%b sum=%0d id=%0d exp=1/99/2", bus.res_valid, bus.res_sum, bus.res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    fill_lane(0, 32'd5, 32'd5);
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_grant got=%b exp=0001", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || dut.ptr !== 2'd0) begin failures++; $display("FAIL rmid_async valid=%b ptr=%0d exp=0/0", bus.res_valid, dut.ptr); end
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_sum !== 64'd0) begin failures++; $display("FAIL rmid_no_result valid=%b sum=%0d exp=0/0", bus.res_valid, bus.res_sum); end
    rst = 1'b0;
    fill_lane(2, 32'hFFFF_FFFF, 32'd100);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant2 got=%b exp=0100", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 64'd68 || bus.res_id !== 2'd2) begin
      failures++; $display("FAIL rmid_result valid=%b sum=%0d id=%0d exp=1/68/2", bus.res_valid, bus.res_sum, bus.res_id);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_negative();
    test_gap();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
